// File: rtl/lfsr_tpg.sv
// Fibonacci LFSR test pattern generator for the BIST stimulus path.
// A small IDLE/RUN/DONE controller loads seeds and emits a programmed number of patterns.
module lfsr_tpg #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b1111,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic [CNT_W-1:0] num_patterns_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] pattern_o,
  output logic             pattern_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             seed_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] pattern_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] target_q;
  logic             seed_err_q;

  logic [WIDTH-1:0] tap_bits;
  logic             fb;
  logic [WIDTH-1:0] pattern_d;
  logic             seed_ok;
  logic [WIDTH-1:0] seed_d;
  logic             last_step;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
    assign tap_bits[gi] = pattern_q[gi] & POLY[gi];
  end

  assign fb        = ^tap_bits;
  assign pattern_d = {pattern_q[WIDTH-2:0], fb};

  // A same-cycle start sees the freshly loaded seed when it is acceptable.
  assign seed_ok   = seed_load_i && (seed_in_i != '0);
  assign seed_d    = seed_ok ? seed_in_i : seed_q;
  assign last_step = (cnt_q == target_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seed_q     <= SEED;
      pattern_q  <= SEED;
      cnt_q      <= '0;
      target_q   <= '0;
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          seed_q     <= seed_d;
          seed_err_q <= seed_load_i && (seed_in_i == '0);
          if (start_i) begin
            pattern_q <= seed_d;
            target_q  <= num_patterns_i;
            cnt_q     <= '0;
            state_q   <= (num_patterns_i != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!pause_i) begin
            pattern_q <= pattern_d;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (last_step) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pattern_o       = pattern_q;
  assign pattern_valid_o = (state_q == S_RUN) && !pause_i;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign seed_err_o      = seed_err_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Directed bench for lfsr_tpg: table of runs plus pause and mid-run reset sequences.
module tb_lfsr_tpg;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       seed_load_i;
  logic [3:0] seed_in_i;
  logic [7:0] num_patterns_i;
  logic       pause_i;
  logic [3:0] pattern_o;
  logic       pattern_valid_o;
  logic       busy_o;
  logic       done_o;
  logic       seed_err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_tpg dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .seed_load_i     (seed_load_i),
    .seed_in_i       (seed_in_i),
    .num_patterns_i  (num_patterns_i),
    .pause_i         (pause_i),
    .pattern_o       (pattern_o),
    .pattern_valid_o (pattern_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .seed_err_o      (seed_err_o)
  );

  typedef struct {
    logic       load;
    logic       combo;
    logic [3:0] seed;
    logic [7:0] n;
    int         sidx;
    logic       err;
  } vec_t;

  vec_t       vecs[7];
  logic [3:0] seq[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int v);
    vec_t x;
    x = vecs[v];
    if (x.load && !x.combo) begin
      @(negedge clk);
      seed_load_i = 1'b1;
      seed_in_i   = x.seed;
      @(negedge clk);
      seed_load_i = 1'b0;
      check($sformatf("v%0d seed_err after load", v), 32'(seed_err_o), 32'(x.err));
      check($sformatf("v%0d busy after load", v), 32'(busy_o), 0);
      @(negedge clk);
      check($sformatf("v%0d seed_err one cycle", v), 32'(seed_err_o), 0);
    end
    @(negedge clk);
    start_i        = 1'b1;
    num_patterns_i = x.n;
    if (x.load && x.combo) begin
      seed_load_i = 1'b1;
      seed_in_i   = x.seed;
    end
    @(negedge clk);
    start_i     = 1'b0;
    seed_load_i = 1'b0;
    if (x.load && x.combo)
      check($sformatf("v%0d seed_err combo", v), 32'(seed_err_o), 32'(x.err));
    for (int j = 0; j < int'(x.n); j++) begin
      check($sformatf("v%0d valid[%0d]", v, j), 32'(pattern_valid_o), 1);
      check($sformatf("v%0d pattern[%0d]", v, j), 32'(pattern_o), 32'(seq[(x.sidx + j) % 15]));
      check($sformatf("v%0d busy[%0d]", v, j), 32'(busy_o), 1);
      @(negedge clk);
    end
    check($sformatf("v%0d done", v), 32'(done_o), 1);
    check($sformatf("v%0d valid at done", v), 32'(pattern_valid_o), 0);
    check($sformatf("v%0d busy at done", v), 32'(busy_o), 1);
    check($sformatf("v%0d pattern at done", v), 32'(pattern_o), 32'(seq[(x.sidx + int'(x.n)) % 15]));
    @(negedge clk);
    check($sformatf("v%0d done pulse ends", v), 32'(done_o), 0);
    check($sformatf("v%0d idle busy", v), 32'(busy_o), 0);
    $display("[TB] run %0d n=%0d seed_idx=%0d complete", v, x.n, x.sidx);
  endtask

  initial begin
    seq = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
            4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    //          load  combo seed   n      sidx err
    vecs[0] = '{1'b0, 1'b0, 4'h0, 8'd4,  0,   1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'h9, 8'd3,  7,   1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 8'd16, 0,   1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 8'd1,  0,   1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'h6, 8'd2,  9,   1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'h0, 8'd1,  9,   1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 8'd0,  0,   1'b0};

    rst = 1'b1; start_i = 1'b0; seed_load_i = 1'b0; seed_in_i = '0;
    num_patterns_i = '0; pause_i = 1'b0;
    #1;
    check("reset pattern", 32'(pattern_o), 32'hF);
    check("reset valid", 32'(pattern_valid_o), 0);
    check("reset busy", 32'(busy_o), 0);
    check("reset done", 32'(done_o), 0);
    check("reset seed_err", 32'(seed_err_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(v);

    // Pause for three cycles after the second pattern of a 5-pattern run.
    @(negedge clk);
    start_i = 1'b1; num_patterns_i = 8'd5;
    @(negedge clk);
    start_i = 1'b0;
    check("pause p0", 32'(pattern_o), 32'hF);
    @(negedge clk);
    check("pause p1", 32'(pattern_o), 32'hE);
    check("pause v1", 32'(pattern_valid_o), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pause_i = 1'b1;
      #1;
      check($sformatf("paused valid[%0d]", k), 32'(pattern_valid_o), 0);
      check($sformatf("paused hold[%0d]", k), 32'(pattern_o), 32'hC);
      check($sformatf("paused busy[%0d]", k), 32'(busy_o), 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pause_i = 1'b0;
      #1;
      check($sformatf("resume valid[%0d]", k), 32'(pattern_valid_o), 1);
      check($sformatf("resume pattern[%0d]", k), 32'(pattern_o), 32'(seq[2 + k]));
    end
    @(negedge clk);
    check("pause done", 32'(done_o), 1);
    check("pause done pattern", 32'(pattern_o), 32'h2);
    $display("[TB] pause sequence complete");

    // Reset asserted during the second pattern of a 10-pattern run.
    @(negedge clk);
    start_i = 1'b1; num_patterns_i = 8'd10;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("abort p1", 32'(pattern_o), 32'hE);
    rst = 1'b1;
    #1;
    check("abort pattern", 32'(pattern_o), 32'hF);
    check("abort busy", 32'(busy_o), 0);
    check("abort valid", 32'(pattern_valid_o), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort no done[%0d]", k), 32'(done_o), 0);
      check($sformatf("abort idle[%0d]", k), 32'(busy_o), 0);
    end
    $display("[TB] reset abort sequence complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
